tree_sum_accumulator: RTL
=========================

Name: tree_sum_accumulator

Overview:
- Sits directly downstream of the binary tree adder. Consumes its 32-bit signed reduced sum, one beat per handshake.
- Accumulates a runtime-configured number of beats (the K-dimension partial sums of a dot product) into a 32-bit result.
- Emits the result over a valid/ready interface to the writeback stage.
- Back-to-back operation: a new accumulation may start in the same cycle the previous result is accepted.

Parameters:
- DATA_W, 32, width of input beat and result (matches tree adder out_32bit).
- CNT_W, 16, width of the length configuration and beat counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- cfg_len_i  in  CNT_W  beats per accumulation; sampled on the first beat only.
- cfg_signed_i  in  1  1 = signed accumulation, 0 = unsigned; sampled on the first beat only.
- in_data_i  in  DATA_W  tree adder sum.
- in_valid_i  in  1  input beat valid.
- in_ready_o  out  1  accumulator can take a beat.
- out_data_o  out  DATA_W  accumulated result.
- out_overflow_o  out  1  sticky overflow flag for this result.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  downstream accepts result.
- busy_o  out  1  accumulation in progress (state ACCUM).

Behaviour:
- Clock and reset: one clock domain; reset is synchronous, active-high.
- Reset values: state IDLE; acc=0; cnt=0; len_q=0; signed_q=0. Outputs: out_data_o=0, out_overflow_o=0, out_valid_o=0, busy_o=0, in_ready_o=0 during the reset cycle, then 1.
- Handshakes: input beat when in_valid_i & in_ready_o; output accept when out_valid_o & out_ready_i.
- Output stability: out_data_o and out_overflow_o are registered and held stable while out_valid_o & !out_ready_i.
- FSM states: IDLE, ACCUM, OUTPUT.
- IDLE:
  - in_ready_o=1.
  - On a beat: len_q = (cfg_len_i==0 ? 1 : cfg_len_i); signed_q = cfg_signed_i; acc = in_data_i; ovf = 0; cnt = 1.
  - If len_q==1, go to OUTPUT; else go to ACCUM.
- ACCUM:
  - in_ready_o=1, busy_o=1.
  - On a beat: acc = acc + in_data_i (DATA_W bits, wrap-around); cnt++.
  - When the beat makes cnt==len_q, go to OUTPUT.
  - No beat: hold state.
- OUTPUT:
  - out_valid_o=1; in_ready_o = out_ready_i.
  - Accept with no simultaneous beat: go to IDLE.
  - Accept with a simultaneous beat: behave exactly as the IDLE first-beat case in that cycle, i.e. load the new acc, sample cfg, go to ACCUM or OUTPUT. The result is zero-bubble.
- Overflow, sticky over one result:
  - Signed: set when operands share a sign and the sum's sign differs.
  - Unsigned: set on carry out of bit DATA_W-1.
  - Data always wraps; it never saturates.
- Latency: result valid on the cycle after the final beat's handshake. Steady-state throughput is one beat per cycle; 1 idle cycle per result is not required.
- Config changes mid-accumulation: ignored; only values captured at the first beat apply.
- Reset mid-accumulation or while OUTPUT is pending: partial result discarded, no output emitted, IDLE next cycle.
- len_q = 2^CNT_W-1 must work. cnt must not wrap before it reaches len_q.

Decomposition:
- Shared package swirl_acc_pkg holds:
  - the state enum type (IDLE/ACCUM/OUTPUT);
  - localparam defaults DATA_W=32, CNT_W=16;
  - a function add_ovf(a, b, sum, is_signed) returning the overflow bit.
- No sub-module is required. Datapath, counter and FSM stay in one module.

Test Plan:
- Basic run: len=4, signed, beats 10, -3, 7, 1 with out_ready held 1 -> one result 15, overflow=0, out_valid exactly 1 cycle after the 4th beat.
- Length edge cases: len=1, beat -5 -> result 0xFFFFFFFB next cycle. len=0 -> treated as 1, same result.
- Overflow: signed len=2, 0x7FFFFFFF then 1 -> data 0x80000000, overflow=1. Unsigned len=2, 0xFFFFFFFF then 1 -> data 0, overflow=1.
- Backpressure and zero bubble: out_ready=0 for 5 cycles after the result -> data held constant, in_ready=0. Then out_ready=1 together with the first beat of the next run (len=3, beats 1, 2, 3) -> both handshakes complete in the same cycle, next result 6.
- Config change: len changed from 4 to 2 after the first beat -> still 4 beats accumulated.
- Reset mid-run: rst_i asserted after 2 of 4 beats -> no out_valid. The next run (len=2, beats 5, 5) yields 10 with no residue from before reset.

Source files
------------

// File: rtl/swirl_acc_pkg.sv
// Shared types, default widths and overflow helper for the tree-sum accumulator.
package swirl_acc_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    OUTPUT
  } acc_state_e;

  // Overflow of a single a+b step: sign flip for signed, carry-out for unsigned.
  function automatic logic add_ovf(input logic [DATA_W-1:0] a,
                                   input logic [DATA_W-1:0] b,
                                   input logic [DATA_W-1:0] sum,
                                   input logic              is_signed);
    logic [DATA_W:0] wide;
    wide = {1'b0, a} + {1'b0, b};
    if (is_signed) begin
      return (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
    end
    return wide[DATA_W];
  endfunction

endpackage

// File: rtl/tree_sum_accumulator.sv
// Accumulates a configured number of tree-adder beats into one result and
// hands it to writeback over valid/ready, with zero-bubble restart.
module tree_sum_accumulator
  import swirl_acc_pkg::acc_state_e;
  import swirl_acc_pkg::IDLE;
  import swirl_acc_pkg::ACCUM;
  import swirl_acc_pkg::OUTPUT;
  import swirl_acc_pkg::add_ovf;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [CNT_W-1:0]  cfg_len_i,
  input  logic              cfg_signed_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_overflow_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              busy_o
);

  acc_state_e        state, state_nxt;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] sum;
  logic              ovf;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic [CNT_W-1:0]  len_q;
  logic [CNT_W-1:0]  len_eff;
  logic              signed_q;
  logic              beat;
  logic              load;
  logic              add;

  // A zero length is treated as a single-beat accumulation.
  assign len_eff = (cfg_len_i == '0) ? CNT_W'(1) : cfg_len_i;
  assign cnt_inc = cnt + CNT_W'(1);
  assign sum     = acc + in_data_i;

  assign out_data_o     = acc;
  assign out_overflow_o = ovf;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Handshake outputs, datapath strobes and next-state selection.
  always_comb begin
    state_nxt   = state;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    busy_o      = 1'b0;
    load        = 1'b0;
    add         = 1'b0;
    if (!rst_i) begin
      case (state)
        IDLE:    in_ready_o = 1'b1;
        ACCUM:   begin in_ready_o = 1'b1; busy_o = 1'b1; end
        OUTPUT:  begin out_valid_o = 1'b1; in_ready_o = out_ready_i; end
        default: ;
      endcase
    end
    beat = in_valid_i & in_ready_o;
    case (state)
      IDLE: begin
        if (beat) begin
          load      = 1'b1;
          state_nxt = (len_eff == CNT_W'(1)) ? OUTPUT : ACCUM;
        end
      end
      ACCUM: begin
        if (beat) begin
          add = 1'b1;
          if (cnt_inc == len_q) state_nxt = OUTPUT;
        end
      end
      OUTPUT: begin
        // in_ready follows out_ready here, so a beat implies the result is accepted.
        if (out_ready_i) begin
          if (beat) begin
            load      = 1'b1;
            state_nxt = (len_eff == CNT_W'(1)) ? OUTPUT : ACCUM;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Accumulator, sticky overflow, beat counter and captured configuration.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc      <= '0;
      ovf      <= 1'b0;
      cnt      <= '0;
      len_q    <= '0;
      signed_q <= 1'b0;
    end else if (load) begin
      acc      <= in_data_i;
      ovf      <= 1'b0;
      cnt      <= CNT_W'(1);
      len_q    <= len_eff;
      signed_q <= cfg_signed_i;
    end else if (add) begin
      acc <= sum;
      ovf <= ovf | add_ovf(acc, in_data_i, sum, signed_q);
      cnt <= cnt_inc;
    end
  end

endmodule
